// File: rtl/pipe_pkg.sv
// Shared opcode constants and sequencer state encoding for the 5-stage pipeline control.
package pipe_pkg;

  localparam logic [3:0] OP_LW  = 4'b1001;
  localparam logic [3:0] OP_BR  = 4'b0010;
  localparam logic [3:0] OP_JAL = 4'b0110;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    REDIR   = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds a source read in DEC.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REGBITS = 4
) (
  input  logic [3:0]         ex_op,
  input  logic [REGBITS-1:0] ex_rd,
  input  logic [REGBITS-1:0] dec_rs1,
  input  logic [REGBITS-1:0] dec_rs2,
  input  logic [1:0]         dec_rs_used,
  output logic               load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = dec_rs_used[0] && (dec_rs1 == ex_rd);
  assign rs2_hit = dec_rs_used[1] && (dec_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = (ex_op == OP_LW) && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_sequencer.sv
// Central stall/flush/redirect FSM for the IF/DEC/EX/MEM/WB pipeline.
// Define PIPE_PERF_CNT_EN to add the perf_stall_cycles/perf_flushes/perf_mem_wait counters.
module pipe_sequencer
  import pipe_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int REGBITS   = 4,
  parameter int REDIR_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         dec_op,
  input  logic [REGBITS-1:0] dec_rs1,
  input  logic [REGBITS-1:0] dec_rs2,
  input  logic [1:0]         dec_rs_used,
  input  logic [3:0]         ex_op,
  input  logic [REGBITS-1:0] ex_rd,
  input  logic               ex_redirect,
  input  logic [DBITS-1:0]   ex_target,
  input  logic               mem_req,
  input  logic               mem_ack,
  output logic               stall_if,
  output logic               stall_dec,
  output logic               bubble_ex,
  output logic               flush_if_dec,
  output logic               freeze,
  output logic               pc_redirect_valid,
  output logic [DBITS-1:0]   pc_redirect,
  output logic               if_valid
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flushes,
  output logic [31:0]        perf_mem_wait
`endif
);

  localparam logic [2:0] REDIR_LOAD = 3'(REDIR_LAT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load_use;
  logic       mem_stall;
  logic       run_cycle;
  logic       unused_dec_op;

  // Opcode in DEC is not needed: rs_used already says which sources are read.
  assign unused_dec_op = ^dec_op;

  hazard_detect #(.REGBITS(REGBITS)) u_hazard (
    .ex_op       (ex_op),
    .ex_rd       (ex_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rs_used (dec_rs_used),
    .load_use    (load_use)
  );

  assign mem_stall   = mem_req && !mem_ack;
  // The ack cycle of a memory wait is handled exactly like a normal RUN cycle.
  assign run_cycle   = (state_q != REDIR) && ((state_q != MEMWAIT) || mem_ack);
  assign pc_redirect = ex_target;

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path infers a latch.
    state_d           = state_q;
    cnt_d             = cnt_q;
    stall_if          = 1'b0;
    stall_dec         = 1'b0;
    bubble_ex         = 1'b0;
    flush_if_dec      = 1'b0;
    freeze            = 1'b0;
    pc_redirect_valid = 1'b0;
    if_valid          = 1'b0;

    if (state_q == REDIR) begin
      if (mem_stall) begin
        freeze = 1'b1;
      end else begin
        bubble_ex = 1'b1;
        if (cnt_q == 3'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
    end else if (!run_cycle) begin
      freeze = 1'b1;
    end else if (mem_stall) begin
      freeze  = 1'b1;
      state_d = MEMWAIT;
    end else if (ex_redirect) begin
      pc_redirect_valid = 1'b1;
      flush_if_dec      = 1'b1;
      bubble_ex         = 1'b1;
      state_d           = REDIR;
      cnt_d             = REDIR_LOAD;
    end else begin
      state_d = RUN;
      if (load_use) begin
        stall_if  = 1'b1;
        stall_dec = 1'b1;
        bubble_ex = 1'b1;
      end else begin
        if_valid = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cycles <= 32'd0;
      perf_flushes      <= 32'd0;
      perf_mem_wait     <= 32'd0;
    end else begin
      if (stall_if || freeze) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (pc_redirect_valid)  perf_flushes      <= perf_flushes + 32'd1;
      if (state_q == MEMWAIT) perf_mem_wait     <= perf_mem_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Randomised bench for pipe_sequencer against a cycle-level behavioural model of the control rules.
module tb_pipe_sequencer;
  import pipe_pkg::*;

  localparam int DBITS   = 32;
  localparam int REGBITS = 4;
  localparam int LAT     = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [3:0]         dec_op = '0;
  logic [REGBITS-1:0] dec_rs1 = '0, dec_rs2 = '0, ex_rd = '0;
  logic [1:0]         dec_rs_used = '0;
  logic [3:0]         ex_op = '0;
  logic               ex_redirect = 1'b0;
  logic [DBITS-1:0]   ex_target = '0;
  logic               mem_req = 1'b0, mem_ack = 1'b0;
  logic               stall_if, stall_dec, bubble_ex, flush_if_dec, freeze;
  logic               pc_redirect_valid, if_valid;
  logic [DBITS-1:0]   pc_redirect;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]        perf_stall_cycles, perf_flushes, perf_mem_wait;
`endif

  pipe_sequencer #(.DBITS(DBITS), .REGBITS(REGBITS), .REDIR_LAT(LAT)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .dec_op            (dec_op),
    .dec_rs1           (dec_rs1),
    .dec_rs2           (dec_rs2),
    .dec_rs_used       (dec_rs_used),
    .ex_op             (ex_op),
    .ex_rd             (ex_rd),
    .ex_redirect       (ex_redirect),
    .ex_target         (ex_target),
    .mem_req           (mem_req),
    .mem_ack           (mem_ack),
    .stall_if          (stall_if),
    .stall_dec         (stall_dec),
    .bubble_ex         (bubble_ex),
    .flush_if_dec      (flush_if_dec),
    .freeze            (freeze),
    .pc_redirect_valid (pc_redirect_valid),
    .pc_redirect       (pc_redirect),
    .if_valid          (if_valid)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_mem_wait     (perf_mem_wait)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: memory access outstanding, and number of fetch-dead cycles still owed to a redirect.
  bit          m_busy = 1'b0;
  int          m_left = 0;
  int unsigned m_stalls = 0, m_flushes = 0, m_waits = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {stall_if, stall_dec, bubble_ex, flush_if_dec, freeze, pc_redirect_valid, if_valid};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_left = 0;
    m_stalls = 0; m_flushes = 0; m_waits = 0;
  endtask

  // Apply one cycle of inputs after the falling edge, compare outputs against the model.
  task automatic step(input logic [3:0] eop, input logic [3:0] erd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [1:0] used, input logic redir,
                      input logic [31:0] tgt, input logic mreq, input logic mack);
    bit lu, s, b, f, z, v, iv, was_wait;
    @(negedge clk);
    ex_op = eop; ex_rd = erd; dec_rs1 = rs1; dec_rs2 = rs2; dec_rs_used = used;
    dec_op = 4'($urandom_range(0, 15));
    ex_redirect = redir; ex_target = tgt; mem_req = mreq; mem_ack = mack;
    #1;
    lu = (eop == OP_LW) && (erd != 0) && ((used[0] && rs1 == erd) || (used[1] && rs2 == erd));
    {s, b, f, z, v, iv} = '0;
    was_wait = m_busy;
    if (m_left > 0) begin
      if (mreq && !mack) z = 1;
      else begin b = 1; m_left--; end
    end else if (m_busy && !mack) begin
      z = 1;
    end else begin
      m_busy = 0;
      if (mreq && !mack) begin z = 1; m_busy = 1; end
      else if (redir) begin v = 1; f = 1; b = 1; m_left = LAT + 1; end
      else if (lu) begin s = 1; b = 1; end
      else iv = 1;
    end
    check("ctl", 32'(ctl_now()), 32'({s, s, b, f, z, v, iv}));
    if (v) check("pc", pc_redirect, tgt);
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall", perf_stall_cycles, m_stalls);
    check("perf_flush", perf_flushes, m_flushes);
    check("perf_wait", perf_mem_wait, m_waits);
`endif
    if (s || z) m_stalls++;
    if (v) m_flushes++;
    if (was_wait) m_waits++;
  endtask

  task automatic idle();
    step(4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int cnt;
    #1;
    check("reset_ctl", 32'(ctl_now()), 32'(7'b0000001));
    @(negedge clk);
    reset_n = 1'b1;

    // Load-use on rs1, then the same load to x0 which must not stall.
    step(OP_LW, 4'd3, 4'd3, 4'd7, 2'b01, 1'b0, 32'd0, 1'b0, 1'b0);
    check("lu_stall", 32'({stall_if, stall_dec, bubble_ex}), 32'(3'b111));
    step(OP_LW, 4'd0, 4'd0, 4'd0, 2'b11, 1'b0, 32'd0, 1'b0, 1'b0);
    check("lu_x0", 32'(stall_if), 32'd0);

    // Redirect wins over a simultaneous load-use.
    step(OP_LW, 4'd5, 4'd5, 4'd0, 2'b01, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    check("prio_stall", 32'(stall_if), 32'd0);
    cnt = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      idle();
      if (!if_valid) cnt++;
    end
    check("redir_len", 32'(cnt), 32'(LAT + 1));

    // Memory wait of four frozen cycles, redirect applied on the ack cycle.
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 32'h100, 1'b1, 1'b0);
      if (freeze) cnt++;
    end
    check("mem_freeze", 32'(cnt), 32'd4);
    step(4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
    check("ack_redir", 32'(pc_redirect_valid), 32'd1);
    for (int i = 0; i < LAT + 2; i++) idle();

    // Reset while the redirect counter sits at 1.
    step(4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 32'h200, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    ex_redirect = 1'b0; mem_req = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_redir", 32'(ctl_now()), 32'(7'b0000001));
    model_reset();
    #1 reset_n = 1'b1;

    // One redirect plus two load-use stalls for the perf counters.
    step(4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 32'h80, 1'b0, 1'b0);
    for (int i = 0; i < LAT + 1; i++) idle();
    step(OP_LW, 4'd2, 4'd0, 4'd2, 2'b10, 1'b0, 32'd0, 1'b0, 1'b0);
    step(OP_LW, 4'd9, 4'd9, 4'd9, 2'b11, 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
`ifdef PIPE_PERF_CNT_EN
    check("perf_flush_cnt", perf_flushes, 32'd1);
    check("perf_stall_cnt", perf_stall_cycles, 32'd2);
`endif

    // Randomised traffic with small register indices so hazards collide often.
    for (int i = 0; i < 3000; i++) begin
      logic mreq, mack, redir;
      logic [3:0] eop;
      mreq  = m_busy ? 1'b1 : ($urandom_range(0, 3) == 0);
      mack  = ($urandom_range(0, 2) == 0);
      redir = (m_left == 0) && ($urandom_range(0, 7) == 0);
      eop   = ($urandom_range(0, 1) == 0) ? OP_LW : 4'($urandom_range(0, 15));
      step(eop, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), redir, $urandom, mreq, mack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Central stall/flush/redirect controller for the 5-stage CPU pipeline (IF, DEC, EX, MEM, WB). Detects load-use hazards between DEC and EX, applies taken-branch/JAL redirects resolved in EX, and freezes the whole pipe while a data-memory access is outstanding. It replaces the per-hazard stall logic with one FSM that drives every stage's enable and bubble-insert line.

## Interface
- DBITS, 32, PC/address width
- REGBITS, 4, register-index width
- REDIR_LAT, 1, cycles after a redirect before instruction memory returns valid target data (1..7)
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- dec_op  in  4  opcode in DEC
- dec_rs1, dec_rs2  in  REGBITS  DEC source registers
- dec_rs_used  in  2  bit0 = rs1 read, bit1 = rs2 read
- ex_op  in  4  opcode in EX
- ex_rd  in  REGBITS  EX destination register
- ex_redirect  in  1  EX resolved taken branch or JAL
- ex_target  in  DBITS  redirect target PC
- mem_req  in  1  MEM stage issuing a data access this cycle
- mem_ack  in  1  data memory completes the access
- stall_if, stall_dec  out  1  hold IF PC / DEC latch
- bubble_ex  out  1  load NOP into DEC→EX latch
- flush_if_dec  out  1  kill instruction in IF→DEC latch
- freeze  out  1  hold every pipeline latch (IF..MEM/WB)
- pc_redirect_valid  out  1  IF loads pc_redirect
- pc_redirect  out  DBITS  next PC on redirect
- if_valid  out  1  IF output is a real instruction

## Operation
- States: RUN, MEMWAIT, REDIR.
- RUN, priority order (first match wins):
  - mem_req & !mem_ack → freeze=1, next MEMWAIT. No other control output asserted.
  - ex_redirect → pc_redirect_valid=1, pc_redirect=ex_target, flush_if_dec=1, bubble_ex=1; next REDIR, counter loaded with REDIR_LAT.
  - Load-use: ex_op==OP_LW, ex_rd!=0, ex_rd matches a used DEC source → stall_if=stall_dec=1, bubble_ex=1; stay RUN.
  - Otherwise all outputs 0 except if_valid=1.
- MEMWAIT: freeze=1 until mem_ack. The ack cycle behaves exactly as RUN, so a redirect or load-use waiting in EX is applied in that cycle. An EX redirect never bypasses an older outstanding memory access.
- REDIR: if_valid=0, bubble_ex=1 (garbage fetches never reach EX). Counter decrements each cycle; at 0 → RUN. mem_req & !mem_ack in REDIR → freeze=1, counter holds, state stays REDIR. A new ex_redirect cannot occur in REDIR because EX holds bubbles.
- Register 0 never causes a load-use stall.
- Opcode values: OP_LW=4'b1001, OP_BR=4'b0010, OP_JAL=4'b0110.

## Timing
- Reset (async, reset_n=0): state RUN, counter 0. All outputs 0 except if_valid=1. Reset mid-MEMWAIT or mid-REDIR returns to RUN immediately and clears the counter.
- All outputs are combinational from the registered state/counter and the current inputs. State and counter update on the rising clk edge.
- Load-use penalty: 1 cycle. Redirect penalty: 1 + REDIR_LAT cycles with if_valid=0. Memory penalty: cycles until mem_ack.
- pc_redirect_valid is high for exactly one cycle per redirect.

## Configuration
- PIPE_PERF_CNT_EN defined: adds 32-bit outputs perf_stall_cycles (+1 per cycle where stall_if|freeze), perf_flushes (+1 per pc_redirect_valid), and perf_mem_wait (+1 per MEMWAIT cycle). Counters reset to 0, wrap at 2^32, and stop counting while reset_n=0.
- Not defined: these ports and counters are absent. Control behaviour is identical either way.

## Structure
- Shared package pipe_pkg: opcode constants (OP_LW, OP_BR, OP_JAL), state enum {RUN, MEMWAIT, REDIR}.
- One sub-module, hazard_detect: combinational load-use compare (dec_rs*, dec_rs_used, ex_op, ex_rd → load_use).
- FSM, counter and optional perf counters live in pipe_sequencer.

## Test plan
- Load-use: ex_op=OP_LW, ex_rd=3, dec_rs1=3, dec_rs_used=01 → one cycle with stall_if=stall_dec=bubble_ex=1. With ex_rd=0 → no stall.
- Redirect: ex_redirect=1, ex_target=0x0000_0040, REDIR_LAT=2 → pc_redirect_valid for 1 cycle with pc_redirect=0x40, then if_valid=0 for 3 cycles, then RUN.
- Memory wait: mem_req=1, mem_ack low 4 cycles → freeze=1 for 4 cycles. On the ack cycle, a pending ex_redirect produces pc_redirect_valid=1.
- Priority: load-use and ex_redirect both true → redirect only, with stall_if=0.
- Reset mid-REDIR: reset_n pulsed low with counter=1 → state RUN, if_valid=1, all other outputs 0 immediately.
- PIPE_PERF_CNT_EN: one redirect plus 2 load-use stalls → perf_flushes=1, perf_stall_cycles=2.
